// File: rtl/mul_sequencer.sv
// Iterative shift-add sequencer for RV32M MUL/MULH/MULHSU/MULHU.
// Optional `MUL_EARLY_OUT_EN: a zero operand at accept jumps straight to DONE.
module mul_sequencer #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] bus_rs1,
    input  logic [31:0] bus_rs2,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] mul_output,
    output logic [4:0]  resp_rd,
    output logic        busy
);

    localparam int N = 32 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic        neg_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [5:0]  cnt_q;
    logic [31:0] out_q;
    logic [4:0]  resp_rd_q;
    logic [31:0] result_d;

    // Operand decode on the accept cycle: signedness follows funct3[1:0].
    logic        rs1_neg, rs2_neg;
    logic [31:0] rs1_mag, rs2_mag;
    logic        zero_operand;
    logic        unused_funct3;

    assign unused_funct3 = funct3[2];
    assign rs1_neg = (funct3[1:0] != 2'b11) & bus_rs1[31];
    assign rs2_neg = ~funct3[1] & bus_rs2[31];
    assign rs1_mag = rs1_neg ? -bus_rs1 : bus_rs1;
    assign rs2_mag = rs2_neg ? -bus_rs2 : bus_rs2;

`ifdef MUL_EARLY_OUT_EN
    assign zero_operand = (bus_rs1 == 32'h0) || (bus_rs2 == 32'h0);
`else
    assign zero_operand = 1'b0;
`endif

    logic [63:0] acc_fixed;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) acc_d = acc_d + (mcand_q << k);
        end
        acc_fixed = neg_q ? -acc_q : acc_q;
        result_d  = (op_q == 2'b00) ? acc_fixed[31:0] : acc_fixed[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            rd_q      <= 5'd0;
            neg_q     <= 1'b0;
            mcand_q   <= 64'h0;
            mplier_q  <= 32'h0;
            acc_q     <= 64'h0;
            cnt_q     <= 6'd0;
            out_q     <= 32'h0;
            resp_rd_q <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= funct3[1:0];
                        rd_q     <= req_rd;
                        neg_q    <= rs1_neg ^ rs2_neg;
                        mcand_q  <= {32'h0, rs1_mag};
                        mplier_q <= rs2_mag;
                        acc_q    <= 64'h0;
                        cnt_q    <= 6'(N);
                        if (zero_operand) begin
                            out_q     <= 32'h0;
                            resp_rd_q <= req_rd;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_q <= S_FIX;
                end
                S_FIX: begin
                    out_q     <= result_d;
                    resp_rd_q <= rd_q;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake and stall outputs decode from the state register alone.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign mul_output = out_q;
    assign resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: transaction-level model compared every cycle,
// plus directed literal cases for signedness corners, backpressure and mid-op reset.
module tb_mul_sequencer;

    localparam int BPC = 1;
    localparam int N   = 32 / BPC;
`ifdef MUL_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] bus_rs1;
    logic [31:0] bus_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] mul_output;
    logic [4:0]  resp_rd;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .bus_rs1    (bus_rs1),
        .bus_rs2    (bus_rs2),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .mul_output (mul_output),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full 64-bit product of the sign- or zero-extended operands, then pick the half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit is_early(input logic [31:0] a, input logic [31:0] b);
        return EARLY && (a == 32'h0 || b == 32'h0);
    endfunction

    // Transaction model: 0 idle, 1 computing (countdown to result), 2 result offered.
    int          m_state = 0;
    int          m_cnt   = 0;
    logic [31:0] m_out   = '0;
    logic [31:0] m_pend  = '0;
    logic [4:0]  m_rd    = '0;
    logic [4:0]  m_pend_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_cnt   = 0;
            m_out   = '0;
            m_rd    = '0;
        end else begin
            case (m_state)
                0: if (req_valid) begin
                    if (is_early(bus_rs1, bus_rs2)) begin
                        m_state = 2;
                        m_out   = '0;
                        m_rd    = req_rd;
                    end else begin
                        m_state   = 1;
                        m_cnt     = N + 1;
                        m_pend    = ref_mul(funct3[1:0], bus_rs1, bus_rs2);
                        m_pend_rd = req_rd;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_state = 2;
                        m_out   = m_pend;
                        m_rd    = m_pend_rd;
                    end
                end
                2: if (resp_ready) m_state = 0;
                default: m_state = 0;
            endcase
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_req_ready",  req_ready,  m_state == 0);
            check("cyc_resp_valid", resp_valid, m_state == 2);
            check("cyc_busy",       busy,       m_state != 0);
            check("cyc_mul_output", mul_output, m_out);
            check("cyc_resp_rd",    resp_rd,    m_rd);
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int waited);
        logic b2;
        b2        = 1'($urandom_range(0, 1));
        req_valid = 1'b1;
        funct3    = {b2, op};
        bus_rs1   = a;
        bus_rs2   = b;
        req_rd    = rd;
        waited    = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 1'b0, 1'b1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        bus_rs1   = $urandom;
        bus_rs2   = $urandom;
        req_rd    = 5'($urandom);
    endtask

    task automatic wait_resp(input bit rnd_ready, output int lat);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            if (rnd_ready) resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        resp_ready = 1'b0;
        if (!resp_valid) check("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic consume(input int hold);
        resp_ready = 1'b0;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold, input bit rnd_ready,
                          input bit lit, input logic [31:0] exp_lit, input int exp_lat_lit);
        int waited, lat;
        issue(op, a, b, rd, waited);
        wait_resp(rnd_ready, lat);
        if (lit) begin
            check("lit_result",  mul_output, exp_lit);
            check("lit_latency", lat, exp_lat_lit);
        end
        check("op_result",  mul_output, ref_mul(op, a, b));
        check("op_latency", lat, is_early(a, b) ? 0 : N + 1);
        check("op_rd",      resp_rd, rd);
        consume(hold);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dirs [6] = '{
        '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000},
        '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        funct3     = 3'b000;
        bus_rs1    = '0;
        bus_rs2    = '0;
        req_rd     = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready",  req_ready,  1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_mul_output", mul_output, 32'h0);
        check("rst_resp_rd",    resp_rd,    5'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        foreach (dirs[i])
            run_op(dirs[i].op, dirs[i].a, dirs[i].b, 5'(i + 1), 0, 1'b0, 1'b1, dirs[i].exp, 33);

        run_op(2'b00, 32'h0, 32'h0000_1234, 5'd7, 0, 1'b0, 1'b1, 32'h0, EARLY ? 0 : 33);

        // Backpressure: result held 10 cycles while a new request waits.
        issue(2'b11, 32'hFFFF_FFFF, 32'h2, 5'h0A, waited);
        wait_resp(1'b0, waited);
        check("bp_first_result", mul_output, 32'h0000_0001);
        check("bp_first_rd",     resp_rd,    5'h0A);
        req_valid = 1'b1;
        funct3    = 3'b000;
        bus_rs1   = 32'd6;
        bus_rs2   = 32'd7;
        req_rd    = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_result",    mul_output, 32'h0000_0001);
            check("bp_hold_rd",        resp_rd,    5'h0A);
            check("bp_hold_req_ready", req_ready,  1'b0);
            check("bp_hold_valid",     resp_valid, 1'b1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_after_hs_req_ready", req_ready,  1'b1);
        check("bp_after_hs_valid",     resp_valid, 1'b0);
        issue(2'b00, 32'd6, 32'd7, 5'd3, waited);
        check("bp_accept_wait", waited, 0);
        wait_resp(1'b0, waited);
        check("bp_second_result",  mul_output, 32'd42);
        check("bp_second_latency", waited, 33);
        consume(0);

        // Reset mid-operation, five edges after accept.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5, waited);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready",  req_ready,  1'b1);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_busy",       busy,       1'b0);
        check("mid_rst_mul_output", mul_output, 32'h0);
        check("mid_rst_resp_rd",    resp_rd,    5'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", resp_valid, 1'b0);
        end
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0000_0010, 5'd9, 0, 1'b0, 1'b1, 32'hFFFF_FF00, 33);

        // Randomized traffic with random backpressure and idle gaps.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, 32'h0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
